// File: rtl/tm1638_pkg.sv
// Shared constants, state encoding and word packing for the TM1638 refresh sequencer.
package tm1638_pkg;

    localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
    localparam logic [7:0] CMD_ADDR       = 8'hC0;
    localparam logic [7:0] CMD_DISP       = 8'h80;

    localparam int WORD_EOT      = 17;
    localparam int WORD_HAS_DATA = 16;

    typedef enum logic [2:0] {IDLE, MODE, DATA, CTRL, DONE} state_t;

    // Every word of a frame ends its own STB transaction.
    function automatic logic [17:0] mk_word(input logic has_data, input logic [7:0] cmd,
                                            input logic [7:0] data);
        logic [17:0] w;
        w                = '0;
        w[WORD_EOT]      = 1'b1;
        w[WORD_HAS_DATA] = has_data;
        w[15:8]          = cmd;
        w[7:0]           = data;
        return w;
    endfunction

endpackage

// File: rtl/tm1638_refresh_timer.sv
// Down-counter that flags when a periodic display refresh is due; REFRESH_CYCLES=0 disables it.
module tm1638_refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Reload,
    output logic o_Expired
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES == 0) ? 1 : $clog2(REFRESH_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(REFRESH_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_Reload) begin
            cnt_d = RELOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Zero is a resting state, not an expiry, when periodic refresh is off.
    assign o_Expired = (REFRESH_CYCLES != 0) && (cnt_q == '0);

endmodule

// File: rtl/tm1638_refresh_ctrl.sv
// Owns the 16-byte TM1638 display image and streams MODE/DATA x16/CTRL frames into spi_fifo.
module tm1638_refresh_ctrl
    import tm1638_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 250000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Wr,
    input  logic [3:0]  i_Wr_Addr,
    input  logic [7:0]  i_Wr_Data,
    input  logic [2:0]  i_Bright,
    input  logic        i_Disp_On,
    input  logic        i_FIFO_Full,
    output logic        o_Data_Valid,
    output logic [17:0] o_Data,
    output logic        o_Busy,
    output logic        o_Frame_Done
);

    state_t      state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic        vld_q, vld_d;
    logic [17:0] data_q, data_d;
    logic        dirty_q, dirty_d;
    logic [7:0]  mem_q [16];
    logic        expired;
    logic        leave;
    logic        can_push;

    tm1638_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_timer (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Reload (leave),
        .o_Expired(expired)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        vld_d    = 1'b0;
        data_d   = data_q;
        leave    = 1'b0;
        // A push is never issued in the cycle right after one, so the FIFO full flag has settled.
        can_push = !vld_q && !i_FIFO_Full;
        case (state_q)
            IDLE: begin
                if (dirty_q || expired) begin
                    state_d = MODE;
                    leave   = 1'b1;
                end
            end
            MODE: begin
                if (can_push) begin
                    vld_d   = 1'b1;
                    data_d  = mk_word(1'b0, CMD_DATA_FIXED, 8'h00);
                    addr_d  = 4'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (can_push) begin
                    vld_d  = 1'b1;
                    data_d = mk_word(1'b1, CMD_ADDR | {4'h0, addr_q}, mem_q[addr_q]);
                    addr_d = addr_q + 4'd1;
                    if (addr_q == 4'hF) begin
                        state_d = CTRL;
                    end
                end
            end
            CTRL: begin
                if (can_push) begin
                    vld_d   = 1'b1;
                    data_d  = mk_word(1'b0, CMD_DISP | {4'h0, i_Disp_On, i_Bright}, 8'h00);
                    state_d = DONE;
                end
            end
            DONE: begin
                // A pending restart chains straight into the next frame so o_Busy never drops.
                if (dirty_q || expired) begin
                    state_d = MODE;
                    leave   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        dirty_d = i_Wr ? 1'b1 : (leave ? 1'b0 : dirty_q);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            addr_q  <= 4'd0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            dirty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (i_Wr) begin
            mem_q[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    assign o_Data_Valid = vld_q;
    assign o_Data       = data_q;
    assign o_Busy       = (state_q != IDLE);
    assign o_Frame_Done = (state_q == DONE);

endmodule
